// File: rtl/disp_pkg.sv
// disp_pkg
//   Shared definitions for the 7-segment scan controller: FSM state
//   encoding, the dark segment pattern and the hex -> segment table.
package disp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Active-low segment bus fully off, including the decimal point.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational nibble + decimal point -> active-low segment bus.
//   nibble_i : hex digit to show
//   dp_i     : 1 = decimal point lit
//   seg_o    : {dp,g,f,e,d,c,b,a}, active-low
module seg7_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = ~{dp_i, hex7(nibble_i)};

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Time-multiplexed scan controller for a common-anode 7-segment display.
//   Each digit slot is CLK_DIV cycles: BLANK_CYC cycles dark, then the digit.
//   Display data is double-buffered; the visible copy only changes at a
//   frame boundary or while the scan is idle.
//   clk        : system clock
//   reset      : asynchronous, active-low
//   en         : 1 = scan, 0 = dark and scan held at digit 0
//   data_in    : nibble k drives digit k (k=0 rightmost)
//   dp_in      : decimal point per digit, 1 = lit
//   load       : 1-cycle strobe capturing data_in/dp_in
//   load_ack   : 1-cycle pulse when captured data becomes the visible copy
//   an         : anode select, active-low
//   seg        : {dp,g,f,e,d,c,b,a}, active-low
//   frame_done : 1-cycle pulse after the last digit slot ends
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_IDLE  | scan stopped, display dark, shadow updates freely
//   ST_BLANK | slot start, all anodes off (anti-ghosting gap)
//   ST_SHOW  | current digit driven
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int CLK_DIV    = 5000,
    parameter int BLANK_CYC  = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic                    frame_done
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int DW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYC - 1);
    localparam logic [DW-1:0] PTR_MAX    = DW'(NUM_DIGITS - 1);

    logic [1:0]              state_q, state_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [DW-1:0]           ptr_q, ptr_d;
    logic                    frame_done_q, frame_done_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                    load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              seg_q, seg_d;

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic [7:0] dec_seg;
    logic       shadow_upd;

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        ptr_d        = ptr_q;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            presc_d = '0;
            ptr_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    presc_d = '0;
                    ptr_d   = '0;
                end
                ST_BLANK: begin
                    presc_d = presc_q + PW'(1);
                    if (presc_q == BLANK_LAST) state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (presc_q == PRESC_MAX) begin
                        state_d = ST_BLANK;
                        presc_d = '0;
                        if (ptr_q == PTR_MAX) begin
                            ptr_d        = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q + DW'(1);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                    ptr_d   = '0;
                end
            endcase
        end
    end

    // frame_done_q is high in the first BLANK cycle of the new frame, so a
    // swap made then is in place before digit 0 leaves its blanking gap.
    assign shadow_upd = frame_done_q || (state_q == ST_IDLE);

    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_d        = pend_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        load_ack_d    = 1'b0;
        if (shadow_upd) begin
            if (load) begin
                shadow_data_d = data_in;
                shadow_dp_d   = dp_in;
                pend_d        = 1'b0;
                load_ack_d    = 1'b1;
            end else if (pend_q) begin
                shadow_data_d = pend_data_q;
                shadow_dp_d   = pend_dp_q;
                pend_d        = 1'b0;
                load_ack_d    = 1'b1;
            end
        end else if (load) begin
            pend_data_d = data_in;
            pend_dp_d   = dp_in;
            pend_d      = 1'b1;
        end
    end

    assign cur_nib = shadow_data_q[{ptr_q, 2'b00} +: 4];
    assign cur_dp  = shadow_dp_q[ptr_q];

    seg7_decode u_dec (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .seg_o    (dec_seg)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        if (state_q == ST_SHOW) begin
            an_d[ptr_q] = 1'b0;
            seg_d       = dec_seg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            presc_q       <= '0;
            ptr_q         <= '0;
            frame_done_q  <= 1'b0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_q        <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            load_ack_q    <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
        end else begin
            state_q       <= state_d;
            presc_q       <= presc_d;
            ptr_q         <= ptr_d;
            frame_done_q  <= frame_done_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_q        <= pend_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            load_ack_q    <= load_ack_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
//   Directed bench for disp_scan_ctrl with CLK_DIV=8, BLANK_CYC=2,
//   NUM_DIGITS=4. Edge n counts rising edges since the last reset release;
//   the expected scan position is derived from n and a hand-set offset.
module tb_disp_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load_ack;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_done;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .CLK_DIV    (8),
        .BLANK_CYC  (2),
        .NUM_DIGITS (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n       = 0;
    int          base    = 2;
    int          swap_n  = 0;
    int          ack_n   = 0;
    string       tname   = "init";
    logic [15:0] exp_data  = '0;
    logic [3:0]  exp_dp    = '0;
    logic [15:0] pend_data = '0;
    logic [3:0]  pend_dp   = '0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s.%s edge %0d: got %h, expected %h", tname, tag, n, got, exp);
        end
    endtask

    function automatic logic [7:0] seg_lut(input logic [3:0] nib, input logic dp);
        logic [7:0] s;
        case (nib)
            4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
            4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
            4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
            4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
        endcase
        if (dp) s[7] = 1'b0;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    // Scanning: expected an/seg/frame_done/load_ack per edge.
    task automatic run_to(input int target);
        int         k;
        logic [1:0] dd;
        logic [3:0] ea;
        logic [7:0] es;
        logic       efd;
        while (n < target) begin
            tick();
            if (n == swap_n) begin
                exp_data = pend_data;
                exp_dp   = pend_dp;
            end
            k   = n - base;
            ea  = 4'hF;
            es  = 8'hFF;
            efd = 1'b0;
            if (k >= 0) begin
                dd = 2'((k / 8) % 4);
                if ((k % 8) >= 2) begin
                    ea[dd] = 1'b0;
                    es     = seg_lut(exp_data[{dd, 2'b00} +: 4], exp_dp[dd]);
                end
                efd = ((k % 32) == 31);
            end
            chk("an", 16'(an), 16'(ea));
            chk("seg", 16'(seg), 16'(es));
            chk("frame_done", 16'(frame_done), 16'(efd));
            chk("load_ack", 16'(load_ack), 16'(n == ack_n));
        end
    endtask

    // Scan held (en=0): display must stay dark with no frame_done.
    task automatic idle_run(input int target);
        while (n < target) begin
            tick();
            chk("idle_an", 16'(an), 16'h000F);
            chk("idle_seg", 16'(seg), 16'h00FF);
            chk("idle_fd", 16'(frame_done), 16'h0000);
            chk("idle_ack", 16'(load_ack), 16'(n == ack_n));
        end
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp);
        data_in = d;
        dp_in   = dp;
        load    = 1'b1;
        run_to(n + 1);
        load    = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        data_in = '0;
        dp_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        tname = "reset";
        chk("an", 16'(an), 16'h000F);
        chk("seg", 16'(seg), 16'h00FF);
        chk("load_ack", 16'(load_ack), 16'h0000);
        chk("frame_done", 16'(frame_done), 16'h0000);

        // 1: free-running scan of an all-zero shadow
        reset = 1'b1;
        n     = 0;
        base  = 2;
        tname = "t1";
        run_to(66);

        // 2: mid-frame load waits for the boundary after edge 97
        tname = "t2";
        run_to(70);
        pend_data = 16'h12AF;
        pend_dp   = 4'b0100;
        swap_n    = 98;
        ack_n     = 98;
        pulse_load(16'h12AF, 4'b0100);
        run_to(100);
        chk("d0_F", 16'(seg), 16'h008E);
        run_to(116);
        chk("d2_2dp", 16'(seg), 16'h0024);
        chk("d2_an", 16'(an), 16'h000B);

        // 3: load in the frame_done cycle goes straight to the shadow
        tname = "t3";
        run_to(129);
        chk("fd_seen", 16'(frame_done), 16'h0001);
        pend_data = 16'h3456;
        pend_dp   = 4'b0001;
        swap_n    = 130;
        ack_n     = 130;
        pulse_load(16'h3456, 4'b0001);
        run_to(132);
        chk("d0_6dp", 16'(seg), 16'h0002);

        // 4: two loads in one frame, last wins, one ack
        tname = "t4";
        run_to(140);
        pend_data = 16'h2222;
        pend_dp   = 4'b0000;
        swap_n    = 162;
        ack_n     = 162;
        pulse_load(16'h1111, 4'b0000);
        run_to(150);
        pulse_load(16'h2222, 4'b0000);
        run_to(172);
        chk("d1_2", 16'(seg), 16'h00A4);
        run_to(175);

        // 5: en dropped during digit 2, loads while idle, restart
        tname = "t5";
        pulse_load(16'h5A5A, 4'b0000);
        run_to(181);
        chk("d2_lit", 16'(an), 16'h000B);
        en = 1'b0;
        tick();
        chk("first_edge_an", 16'(an), 16'h000B);
        chk("first_edge_seg", 16'(seg), 16'h00A4);
        chk("first_edge_fd", 16'(frame_done), 16'h0000);
        chk("first_edge_ack", 16'(load_ack), 16'h0000);
        ack_n = 183;
        idle_run(189);
        data_in = 16'h9876;
        dp_in   = 4'b1000;
        load    = 1'b1;
        ack_n   = 190;
        idle_run(190);
        load    = 1'b0;
        idle_run(200);
        en       = 1'b1;
        base     = 202;
        exp_data = 16'h9876;
        exp_dp   = 4'b1000;
        swap_n   = 0;
        ack_n    = 0;
        run_to(228);
        chk("d3_9dp", 16'(seg), 16'h0010);
        run_to(240);

        // 6: asynchronous reset mid-SHOW drops pending and shadow data
        tname = "t6";
        pulse_load(16'hFFFF, 4'hF);
        run_to(245);
        chk("pre_an", 16'(an), 16'h000D);
        #2;
        reset = 1'b0;
        #1;
        chk("async_an", 16'(an), 16'h000F);
        chk("async_seg", 16'(seg), 16'h00FF);
        chk("async_ack", 16'(load_ack), 16'h0000);
        chk("async_fd", 16'(frame_done), 16'h0000);
        #20;
        reset    = 1'b1;
        n        = 0;
        base     = 2;
        exp_data = '0;
        exp_dp   = '0;
        swap_n   = 0;
        ack_n    = 0;
        run_to(70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
